// File: rtl/conv_pkg.sv
// Shared state encoding, widths and the result saturation helper for the 3x3 convolver.
package conv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t MAC   = 2'd1;
    localparam state_t WRITE = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam int KTAPS = 9;
    localparam int ACC_W = 21;
    localparam int RES_W = 16;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    function automatic logic signed [RES_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        if (acc > SAT_MAX) begin
            return 16'sh7FFF;
        end else if (acc < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return acc[RES_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Row/column/tap counters for the 3x3 window walk and the pixel address they imply.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              step_tap,
    input  logic              step_pix,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        tap,
    output logic              last_tap,
    output logic              last_pixel
);

    localparam int OUT_W = IMG_W - 2;
    localparam int CW    = $clog2(IMG_W);

    logic [CW-1:0]     row;
    logic [CW-1:0]     col;
    logic [1:0]        ky;
    logic [1:0]        kx;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] addr_q;
    int                addr_int;

    always_comb begin
        addr_int = (int'(row) + int'(ky)) * IMG_W + int'(col) + int'(kx);
        addr_cur = ADDR_W'(addr_int);
    end

    assign last_tap   = (tap == 4'(KTAPS - 1));
    assign last_pixel = (row == CW'(OUT_W - 1)) && (col == CW'(OUT_W - 1));

    // Outside the MAC phase the address bus parks on the last tap address issued.
    assign pix_addr = step_tap ? addr_cur : addr_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row    <= '0;
            col    <= '0;
            tap    <= '0;
            ky     <= '0;
            kx     <= '0;
            addr_q <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
            tap <= '0;
            ky  <= '0;
            kx  <= '0;
        end else begin
            if (step_tap) begin
                addr_q <= addr_cur;
                if (last_tap) begin
                    tap <= '0;
                    ky  <= '0;
                    kx  <= '0;
                end else begin
                    tap <= tap + 4'd1;
                    if (kx == 2'd2) begin
                        kx <= '0;
                        ky <= ky + 2'd1;
                    end else begin
                        kx <= kx + 2'd1;
                    end
                end
            end
            if (step_pix) begin
                if (col == CW'(OUT_W - 1)) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_engine.sv
// 3x3 convolution engine: nine MAC cycles per output, then a saturated write into the result FIFO.
//  state | meaning
//  IDLE  | waiting for start; kernel latched when it arrives
//  MAC   | one tap per cycle accumulated into acc
//  WRITE | presenting sat16(acc) until the FIFO has room
//  DONE  | one-cycle completion pulse
module conv_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [71:0]       kernel,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [7:0]        pix_data,
    input  logic              res_full,
    output logic              res_wenable,
    output logic [15:0]       result_out,
    output logic              busy,
    output logic              done
);

    state_t                    state;
    logic [71:0]               kern_q;
    logic signed [ACC_W-1:0]   acc;
    logic [3:0]                tap;
    logic                      last_tap;
    logic                      last_pixel;
    logic signed [7:0]         k_tap;
    logic signed [16:0]        prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      accept;
    logic                      in_mac;
    logic                      wr;

    assign accept = (state == IDLE) && start;
    assign in_mac = (state == MAC);
    assign wr     = (state == WRITE) && !res_full;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (accept),
        .step_tap   (in_mac),
        .step_pix   (wr),
        .pix_addr   (pix_addr),
        .tap        (tap),
        .last_tap   (last_tap),
        .last_pixel (last_pixel)
    );

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    assign k_tap    = kern_q[{tap, 3'b000} +: 8];
    assign prod     = $signed({1'b0, pix_data}) * k_tap;
    assign prod_ext = {{(ACC_W - 17){prod[16]}}, prod};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            kern_q <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        kern_q <= kernel;
                        acc    <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (last_tap) state <= WRITE;
                end
                WRITE: begin
                    if (!res_full) begin
                        acc   <= '0;
                        state <= last_pixel ? DONE : MAC;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign res_wenable = wr;
    assign result_out  = (state == WRITE) ? sat16(acc) : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: table of kernel/image cases, reference convolution feeding a result scoreboard.
module tb_conv_engine;

    localparam int IMG_W  = 28;
    localparam int ADDR_W = 10;
    localparam int OUT_W  = IMG_W - 2;
    localparam int NRES   = OUT_W * OUT_W;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [71:0]       kernel;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;
    logic              res_full;
    logic              res_wenable;
    logic [15:0]       result_out;
    logic              busy;
    logic              done;

    logic [7:0]  img [1024];
    logic [15:0] sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          base;

    typedef struct {
        string       name;
        logic [71:0] kern;
        int          img_mode;
        logic [15:0] exp0;
        logic [15:0] exp26;
        bit          chk;
        bit          stall;
        bit          restart;
        int          exp_done;
    } vec_t;

    vec_t vecs [7];

    conv_engine #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .kernel      (kernel),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .res_full    (res_full),
        .res_wenable (res_wenable),
        .result_out  (result_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign pix_data = img[pix_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic set_image(input int mode);
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                0:       img[a] = 8'd1;
                1:       img[a] = 8'(a);
                2:       img[a] = 8'd255;
                default: img[a] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    function automatic logic [15:0] ref_val(input logic [71:0] k, input int r, input int c);
        int s;
        logic signed [7:0] t;
        s = 0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                t = k[8*(ky*3+kx) +: 8];
                s += int'(img[(r+ky)*IMG_W + c + kx]) * int'(t);
            end
        end
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // One full run; reset_at > 0 pulls n_rst low at that relative cycle and returns.
    task automatic run(input logic [71:0] k, input bit stall, input bit restart, input int reset_at,
                       output logic [15:0] got0, output logic [15:0] got26, output int nwr,
                       output int first_wr, output int done_rel, output int done_cnt,
                       output int busy_first, output int busy_last);
        logic [15:0] held;
        logic [15:0] e;
        int rel;
        sb.delete();
        for (int r = 0; r < OUT_W; r++)
            for (int c = 0; c < OUT_W; c++)
                sb.push_back(ref_val(k, r, c));
        nwr = 0; first_wr = -1; done_rel = -1; done_cnt = 0;
        busy_first = -1; busy_last = -1; got0 = 'x; got26 = 'x; held = '0;
        @(negedge clk);
        base = cyc;
        kernel = k;
        for (int i = 0; i < 8000; i++) begin
            if (i > 0) @(negedge clk);
            rel = cyc - base;
            start = (rel == 0) || (restart && rel == 100);
            if (rel == 3) kernel = ~k;
            res_full = stall && rel >= 30 && rel < 35;
            if (reset_at > 0 && rel == reset_at) begin
                n_rst = 1'b0;
                #1;
                check("rst_pix_addr", pix_addr, 0);
                check("rst_wenable", res_wenable, 0);
                check("rst_result", result_out, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                start = 1'b0;
                res_full = 1'b0;
                return;
            end
            #1;
            if (busy) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (res_full) begin
                check("wen_while_full", res_wenable, 0);
                if (rel == 30) begin
                    held = result_out;
                    check("stall_result", result_out, (sb.size() > 0) ? sb[0] : 16'hxxxx);
                end else begin
                    check("stall_hold", result_out, held);
                end
            end
            if (res_wenable) begin
                if (first_wr < 0) first_wr = rel;
                if (nwr == 0) got0 = result_out;
                if (nwr == 26) got26 = result_out;
                if (sb.size() == 0) begin
                    check("extra_write", nwr + 1, NRES);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("res[%0d]", nwr), result_out, e);
                end
                nwr++;
            end
            if (done_rel >= 0 && rel >= done_rel + 2) break;
        end
        start = 1'b0;
        res_full = 1'b0;
    endtask

    initial begin
        logic [15:0] got0, got26;
        int nwr, first_wr, done_rel, done_cnt, busy_first, busy_last;
        logic [71:0] ident;

        n_rst = 1'b0; start = 1'b0; res_full = 1'b0; kernel = '0;
        set_image(0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_pix_addr", pix_addr, 0);
        check("reset_wenable", res_wenable, 0);
        check("reset_result", result_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        n_rst = 1'b1;

        ident = 72'd1 << 32;
        vecs[0] = '{"ones",      {9{8'h01}}, 0, 16'd9,      16'd9,      1'b1, 1'b0, 1'b0, 6761};
        vecs[1] = '{"identity",  ident,      1, 16'd29,     16'd57,     1'b1, 1'b0, 1'b0, 6761};
        vecs[2] = '{"sat_pos",   {9{8'h7F}}, 2, 16'h7FFF,   16'h7FFF,   1'b1, 1'b0, 1'b0, 6761};
        vecs[3] = '{"sat_neg",   {9{8'h80}}, 2, 16'h8000,   16'h8000,   1'b1, 1'b0, 1'b0, 6761};
        vecs[4] = '{"stall",     {9{8'h01}}, 0, 16'd9,      16'd9,      1'b1, 1'b1, 1'b0, 6766};
        vecs[5] = '{"restart",   ident,      1, 16'd29,     16'd57,     1'b1, 1'b0, 1'b1, 6761};
        vecs[6] = '{"random",    72'({$urandom(), $urandom(), $urandom()}), 3, 16'd0, 16'd0,
                    1'b0, 1'b0, 1'b0, 6761};

        for (int v = 0; v < 7; v++) begin
            set_image(vecs[v].img_mode);
            run(vecs[v].kern, vecs[v].stall, vecs[v].restart, 0,
                got0, got26, nwr, first_wr, done_rel, done_cnt, busy_first, busy_last);
            if (vecs[v].chk) begin
                check({vecs[v].name, "_first"}, got0, vecs[v].exp0);
                check({vecs[v].name, "_idx26"}, got26, vecs[v].exp26);
            end
            check({vecs[v].name, "_nwrites"}, nwr, NRES);
            check({vecs[v].name, "_first_wr_cyc"}, first_wr, 10);
            check({vecs[v].name, "_done_cyc"}, done_rel, vecs[v].exp_done);
            check({vecs[v].name, "_done_pulses"}, done_cnt, 1);
            check({vecs[v].name, "_busy_first"}, busy_first, 1);
            check({vecs[v].name, "_busy_last"}, busy_last, vecs[v].exp_done);
        end

        // Mid-run reset, then a clean run must still produce everything.
        set_image(1);
        run(ident, 1'b0, 1'b0, 2000,
            got0, got26, nwr, first_wr, done_rel, done_cnt, busy_first, busy_last);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        run(ident, 1'b0, 1'b0, 0,
            got0, got26, nwr, first_wr, done_rel, done_cnt, busy_first, busy_last);
        check("after_rst_first", got0, 16'd29);
        check("after_rst_nwrites", nwr, NRES);
        check("after_rst_first_wr_cyc", first_wr, 10);
        check("after_rst_done_cyc", done_rel, 6761);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
